dram_burst: RTL and testbench

//  Parametrised single-clock word-addressed memory model, successor to the CVP14 bench DRAM.

---
 rtl/dram_burst.sv | 142 ++++++++++++++
 tb/tb_dram_burst.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dram_burst.sv
// Word-addressed bench memory with programmable read latency, Busy back-pressure
// and fixed-length burst transfers that move one word per cycle.
module dram_burst #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int DEPTH     = 65536,
   parameter int RD_LAT    = 2,
   parameter int BURST_LEN = 16
) (
   input  logic              Clk1,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] DataIn,
   input  logic              RD,
   input  logic              WR,
   input  logic              Burst,
   output logic [DATA_W-1:0] DataOut,
   output logic              Valid,
   output logic              Busy
);

   localparam int AW       = $clog2(DEPTH);
   localparam int LAT_W    = $clog2(RD_LAT + 1);
   localparam int CNT_W    = $clog2(BURST_LEN);
   localparam int LAT_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;

   typedef enum logic [1:0] {IDLE, RWAIT, RDATA, WBURST} state_t;

   logic [DATA_W-1:0] Memory [0:DEPTH-1];

   state_t            state_q;
   logic [AW-1:0]     addr_q;
   logic [LAT_W-1:0]  lat_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] dout_q;
   logic              valid_q;
   logic              busy_q;

   logic [AW-1:0]     a_idx;
   logic              mem_we;
   logic [AW-1:0]     mem_waddr;

   // Upper address bits alias onto the array.
   assign a_idx = Addr[AW-1:0];

   assign DataOut = dout_q;
   assign Valid   = valid_q;
   assign Busy    = busy_q;

   // Write port: single/first burst word from Addr, later burst words from the pointer.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = addr_q;
      if (!Reset) begin
         case (state_q)
            IDLE: begin
               if (WR) begin
                  mem_we    = 1'b1;
                  mem_waddr = a_idx;
               end
            end
            WBURST:  mem_we = 1'b1;
            default: mem_we = 1'b0;
         endcase
      end
   end

   always_ff @(posedge Clk1) begin
      if (mem_we) Memory[mem_waddr] <= DataIn;
   end

   // cnt_q holds the number of words still to move after the current one.
   always_ff @(posedge Clk1) begin
      if (Reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         lat_q   <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (WR) begin
                  if (Burst) begin
                     addr_q  <= a_idx + 1'b1;
                     cnt_q   <= CNT_W'(BURST_LEN - 2);
                     busy_q  <= 1'b1;
                     state_q <= WBURST;
                  end
               end else if (RD) begin
                  cnt_q  <= Burst ? CNT_W'(BURST_LEN - 1) : '0;
                  busy_q <= 1'b1;
                  if (RD_LAT == 1) begin
                     dout_q  <= Memory[a_idx];
                     valid_q <= 1'b1;
                     addr_q  <= a_idx + 1'b1;
                     state_q <= RDATA;
                  end else begin
                     addr_q  <= a_idx;
                     lat_q   <= LAT_W'(LAT_INIT);
                     state_q <= RWAIT;
                  end
               end
            end
            RWAIT: begin
               if (lat_q == '0) begin
                  dout_q  <= Memory[addr_q];
                  valid_q <= 1'b1;
                  addr_q  <= addr_q + 1'b1;
                  state_q <= RDATA;
               end else begin
                  lat_q <= lat_q - 1'b1;
               end
            end
            RDATA: begin
               if (cnt_q == '0) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  dout_q <= Memory[addr_q];
                  addr_q <= addr_q + 1'b1;
                  cnt_q  <= cnt_q - 1'b1;
               end
            end
            WBURST: begin
               addr_q <= addr_q + 1'b1;
               if (cnt_q == '0) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_burst.sv
// Directed bench for dram_burst: three instances with read latency 2, 1 and 8
// share address/data/write stimulus; reads and resets are per instance.
module tb_dram_burst;

   logic        clk = 1'b0;
   logic [2:0]  rst;
   logic [2:0]  rd;
   logic        wr, burst;
   logic [15:0] addr, din;
   logic [15:0] dout [3];
   logic        vld  [3];
   logic        bsy  [3];

   int checks = 0;
   int errors = 0;
   int busy_cycles;
   logic [15:0] e;

   always #5 clk = ~clk;

   dram_burst #(.RD_LAT(2)) u0 (
      .Clk1(clk), .Reset(rst[0]), .Addr(addr), .DataIn(din), .RD(rd[0]), .WR(wr),
      .Burst(burst), .DataOut(dout[0]), .Valid(vld[0]), .Busy(bsy[0]));
   dram_burst #(.RD_LAT(1)) u1 (
      .Clk1(clk), .Reset(rst[1]), .Addr(addr), .DataIn(din), .RD(rd[1]), .WR(wr),
      .Burst(burst), .DataOut(dout[1]), .Valid(vld[1]), .Busy(bsy[1]));
   dram_burst #(.RD_LAT(8)) u8 (
      .Clk1(clk), .Reset(rst[2]), .Addr(addr), .DataIn(din), .RD(rd[2]), .WR(wr),
      .Burst(burst), .DataOut(dout[2]), .Valid(vld[2]), .Busy(bsy[2]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Burst read interrupted by reset on its 4th word, then a fresh single read.
   task automatic reset_mid_burst(input int k, input int lat);
      rd[k] = 1'b1; burst = 1'b1; addr = 16'h0100;
      tick();
      rd[k] = 1'b0; burst = 1'b0; addr = 16'h0000;
      for (int j = 1; j < lat; j++) tick();
      for (int i = 0; i < 3; i++) begin
         e = 16'hA000 + 16'(i);
         check($sformatf("t6_l%0d_w%0d", lat, i), {15'd0, vld[k], dout[k]}, {16'd1, e});
         tick();
      end
      check($sformatf("t6_l%0d_w3", lat), {15'd0, vld[k], dout[k]}, {16'd1, 16'hA003});
      rst[k] = 1'b1;
      tick();
      rst[k] = 1'b0;
      check($sformatf("t6_l%0d_rst", lat), {14'd0, vld[k], bsy[k], dout[k]}, 32'd0);
      rd[k] = 1'b1; addr = 16'h0010;
      tick();
      rd[k] = 1'b0;
      for (int j = 1; j < lat; j++) begin
         check($sformatf("t6_l%0d_wait%0d", lat, j), {31'd0, vld[k]}, 32'd0);
         tick();
      end
      check($sformatf("t6_l%0d_rd", lat), {14'd0, vld[k], bsy[k], dout[k]}, {16'd3, 16'h1234});
      tick();
      check($sformatf("t6_l%0d_end", lat), {30'd0, vld[k], bsy[k]}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 3'b111; rd = 3'b000; wr = 1'b0; burst = 1'b0; addr = '0; din = '0;

      // 1: reset state and memory retention across reset
      tick(); tick();
      check("t1_dout", {16'd0, dout[0]}, 32'd0);
      check("t1_valid", {31'd0, vld[0]}, 32'd0);
      check("t1_busy", {31'd0, bsy[0]}, 32'd0);
      rst = 3'b000;
      wr = 1'b1; addr = 16'h0005; din = 16'hBEEF;
      tick();
      wr = 1'b0;
      check("t1_wr_busy", {31'd0, bsy[0]}, 32'd0);
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      check("t1_mem_kept", {16'd0, u0.Memory[5]}, {16'd0, 16'hBEEF});

      // 2: single write then single read, latency 2
      wr = 1'b1; addr = 16'h0010; din = 16'h1234;
      tick();
      wr = 1'b0;
      check("t2_wr_busy", {31'd0, bsy[0]}, 32'd0);
      rd[0] = 1'b1; addr = 16'h0010;
      tick();
      rd[0] = 1'b0;
      check("t2_c1", {30'd0, vld[0], bsy[0]}, 32'd1);
      tick();
      check("t2_c2", {14'd0, vld[0], bsy[0], dout[0]}, {16'd3, 16'h1234});
      tick();
      check("t2_c3", {14'd0, vld[0], bsy[0], dout[0]}, {16'd0, 16'h1234});

      // 3: burst write then burst read at 0x0100
      wr = 1'b1; burst = 1'b1; addr = 16'h0100; din = 16'hA000;
      tick();
      wr = 1'b0; burst = 1'b0; addr = 16'h0000;
      busy_cycles = bsy[0] ? 1 : 0;
      for (int i = 1; i < 16; i++) begin
         din = 16'hA000 + 16'(i);
         tick();
         if (bsy[0]) busy_cycles++;
      end
      check("t3_busy_cycles", busy_cycles, 32'd15);
      check("t3_busy_end", {31'd0, bsy[0]}, 32'd0);
      rd[0] = 1'b1; burst = 1'b1; addr = 16'h0100;
      tick();
      rd[0] = 1'b0; burst = 1'b0;
      check("t3_lat", {31'd0, vld[0]}, 32'd0);
      tick();
      for (int i = 0; i < 16; i++) begin
         e = 16'hA000 + 16'(i);
         check($sformatf("t3_word%0d", i), {15'd0, vld[0], dout[0]}, {16'd1, e});
         tick();
      end
      check("t3_done", {30'd0, vld[0], bsy[0]}, 32'd0);

      // 4: wrap-around burst from DEPTH-2, RD pulsed mid-burst
      wr = 1'b1; burst = 1'b1; addr = 16'hFFFE; din = 16'hFFFE;
      tick();
      wr = 1'b0; burst = 1'b0;
      for (int i = 1; i < 16; i++) begin
         din = 16'hFFFE + 16'(i);
         tick();
      end
      check("t4_wr_done", {31'd0, bsy[0]}, 32'd0);
      rd[0] = 1'b1; burst = 1'b1; addr = 16'hFFFE;
      tick();
      rd[0] = 1'b0; burst = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         e = 16'hFFFE + 16'(i);
         check($sformatf("t4_word%0d", i), {15'd0, vld[0], dout[0]}, {16'd1, e});
         rd[0] = (i == 3);
         addr = 16'h0010;
         tick();
      end
      rd[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t4_no_extra%0d", i), {30'd0, vld[0], bsy[0]}, 32'd0);
         tick();
      end

      // 5: RD and WR together -> write wins, no read
      rd[0] = 1'b1; wr = 1'b1; addr = 16'h0020; din = 16'h5555;
      tick();
      rd[0] = 1'b0; wr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t5_idle%0d", i), {30'd0, vld[0], bsy[0]}, 32'd0);
         tick();
      end
      check("t5_mem", {16'd0, u0.Memory[16'h0020]}, {16'd0, 16'h5555});

      // 6: reset on 4th burst word, latencies 2, 1 and 8
      reset_mid_burst(0, 2);
      reset_mid_burst(1, 1);
      reset_mid_burst(2, 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
